// File: rtl/step_sequencer.sv
// step_sequencer: pattern-driven note/gate source for one synth voice, stepping on sample ticks.
// Optional swing timing is compiled in with `define STEP_SEQUENCER_SWING_EN.
module step_sequencer #(
  parameter int STEPS  = 16,
  parameter int NOTE_W = 8,
  parameter int STEP_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clock,
  input  logic              run,
  input  logic [15:0]       step_period,
  input  logic [15:0]       gate_len,
  input  logic [STEP_W-1:0] loop_last,
  input  logic [7:0]        swing,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_gate,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic [STEP_W-1:0] step,
  output logic              step_strobe
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_q;
  logic              sc_s1_q, sc_s2_q, sc_s3_q;
  logic [16:0]       cnt_q;
  logic              gate_en_q;
  logic              gate_q;
  logic              strobe_q;
  logic [NOTE_W-1:0] note_q;
  logic [STEP_W-1:0] step_q;
  logic [NOTE_W:0]   ram_q [STEPS];

  logic              tick;
  logic              load;
  logic [STEP_W-1:0] nxt_step;
  logic [STEP_W-1:0] load_idx;
  logic [NOTE_W:0]   ram_ld;
  logic [16:0]       p_cur, p_ld, gl_cur, gl_ld;
  logic [16:0]       cnt_inc;

`ifdef STEP_SEQUENCER_SWING_EN
  // Swing stretches even steps and shortens odd ones by the same amount, so pairs keep their length.
  function automatic logic [16:0] eff_period(input logic [15:0] period, input logic [7:0] sw,
                                             input logic odd);
    logic [16:0] base;
    logic [16:0] sw_max;
    logic [16:0] sw_c;
    base   = (period < 16'd2) ? 17'd2 : {1'b0, period};
    sw_max = {1'b0, base[16:1]} - 17'd1;
    sw_c   = ({9'd0, sw} > sw_max) ? sw_max : {9'd0, sw};
    eff_period = odd ? (base - sw_c) : (base + sw_c);
  endfunction

  assign p_cur = eff_period(step_period, swing, step_q[0]);
  assign p_ld  = eff_period(step_period, swing, load_idx[0]);
`else
  function automatic logic [16:0] eff_period(input logic [15:0] period);
    eff_period = (period < 16'd2) ? 17'd2 : {1'b0, period};
  endfunction

  logic unused_swing;
  assign unused_swing = ^swing;
  assign p_cur = eff_period(step_period);
  assign p_ld  = eff_period(step_period);
`endif

  // Keeping gate_len below the period forces one low sample per step so the voice retriggers.
  function automatic logic [16:0] clamp_gate(input logic [15:0] glen, input logic [16:0] p);
    clamp_gate = ({1'b0, glen} > (p - 17'd1)) ? (p - 17'd1) : {1'b0, glen};
  endfunction

  assign tick     = sc_s2_q & ~sc_s3_q;
  assign nxt_step = (step_q == loop_last) ? '0 : step_q + 1'b1;
  assign load_idx = (state_q == IDLE) ? '0 : nxt_step;
  assign ram_ld   = ram_q[load_idx];
  assign gl_cur   = clamp_gate(gate_len, p_cur);
  assign gl_ld    = clamp_gate(gate_len, p_ld);
  assign cnt_inc  = cnt_q + 17'd1;

  // ">=" rather than "==" so a period shortened mid-step ends the step instead of counting to wrap.
  always_comb begin
    load = 1'b0;
    if (state_q == IDLE) load = tick & run;
    else                 load = tick & run & (cnt_q >= (p_cur - 17'd1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sc_s1_q   <= 1'b0;
      sc_s2_q   <= 1'b0;
      sc_s3_q   <= 1'b0;
      cnt_q     <= '0;
      gate_en_q <= 1'b0;
      gate_q    <= 1'b0;
      strobe_q  <= 1'b0;
      note_q    <= '0;
      step_q    <= '0;
      for (int i = 0; i < STEPS; i++) ram_q[i] <= '0;
    end else begin
      sc_s1_q  <= sample_clock;
      sc_s2_q  <= sc_s1_q;
      sc_s3_q  <= sc_s2_q;
      strobe_q <= 1'b0;
      if (wr_en) ram_q[wr_addr] <= {wr_gate, wr_note};

      if (load) begin
        state_q   <= PLAY;
        step_q    <= load_idx;
        note_q    <= ram_ld[NOTE_W-1:0];
        gate_en_q <= ram_ld[NOTE_W];
        gate_q    <= ram_ld[NOTE_W] & (gl_ld != 17'd0);
        cnt_q     <= '0;
        strobe_q  <= 1'b1;
      end else if (state_q == PLAY && !run) begin
        state_q   <= IDLE;
        step_q    <= '0;
        cnt_q     <= '0;
        gate_q    <= 1'b0;
        gate_en_q <= 1'b0;
      end else if (state_q == PLAY && tick) begin
        cnt_q  <= cnt_inc;
        gate_q <= gate_en_q & (cnt_inc < gl_cur);
      end
    end
  end

  assign note        = note_q;
  assign gate        = gate_q;
  assign step        = step_q;
  assign step_strobe = strobe_q;

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Pattern-driven note/gate source for one synth voice, sitting directly upstream of a `voice` instance and replacing hard-wired counter gates. Holds a writable pattern of up to `STEPS` steps (note + gate bit). Advances at a programmable tempo counted in sample ticks derived from the `sample_clock` output of the sample-clock divider. Drives `note` and `gate` on the `clk` domain with deterministic, sample-aligned timing.

## Interface
- `STEPS`, 16: pattern length capacity; power of two, 2–64.
- `NOTE_W`, 8: note width; matches the `voice` note port.
- `STEP_W`, $clog2(STEPS): step index width (derived; do not override).
- `clk`  in  1  system clock (8 MHz).
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset); release synchronously to `clk` upstream.
- `sample_clock`  in  1  level output of the sample-clock divider; its rising edge defines one sample tick.
- `run`  in  1  1 = play, 0 = stop and rewind.
- `step_period`  in  16  samples per step; values < 2 are treated as 2.
- `gate_len`  in  16  samples gate is high per step; clamped to effective period − 1.
- `loop_last`  in  STEP_W  last step index before wrap to 0.
- `swing`  in  8  swing amount in samples (see Configuration).
- `wr_en`  in  1  pattern write strobe, one `clk` cycle.
- `wr_addr`  in  STEP_W  step to write.
- `wr_note`  in  NOTE_W  note value for that step.
- `wr_gate`  in  1  1 = step sounds, 0 = rest.
- `note`  out  NOTE_W  current step note; reset 0.
- `gate`  out  1  gate to voice; reset 0.
- `step`  out  STEP_W  current step index; reset 0.
- `step_strobe`  out  1  one-`clk` pulse at each step start; reset 0.

## Operation
- Tick detect: `sample_clock` passes through a 2-flop synchroniser; `tick` = rising edge of synchronised value, one `clk` wide. All counters update only on `tick`.
- Pattern RAM: STEPS × (NOTE_W+1) registers, reset to all zero. Written on any `clk` where `wr_en`=1, regardless of state. A write to the currently playing step does not change `note`/`gate` until that step is next loaded.
- States: IDLE, PLAY.
  - IDLE: `gate`=0, `step`=0, sample counter `cnt`=0. On the first `tick` with `run`=1, load step 0 and go to PLAY.
  - PLAY: on each `tick`, if `cnt` == P−1 (P = effective period of current step), set `cnt`=0, `step` = (`step` == `loop_last`) ? 0 : `step`+1, and load that step. Otherwise `cnt`++.
  - Loading a step: latch `note` from RAM, set gate-enable from the RAM gate bit, pulse `step_strobe`.
  - `gate` = gate-enable AND (`cnt` < clamped `gate_len`), registered. `gate_len`=0 means the gate never rises. The clamp guarantees at least one sample low per step, so the voice retriggers.
  - `run`=0 in PLAY: on the next `clk` (no tick needed), go to IDLE, `gate`=0, `step`=0, `cnt`=0. `note` holds its last value.
- If `step` > `loop_last` after a `loop_last` change, the sequencer continues to STEPS−1 and wraps to 0. Indices wrap modulo STEPS.
- Control inputs (`step_period`, `gate_len`, `loop_last`, `swing`) are sampled on each `tick`. Changes take effect on the next tick with no restart.
- Reset (`rst`=0) mid-operation: all state and outputs go to reset values immediately. Pattern RAM is cleared.

## Timing
- Tick latency: `sample_clock` rising edge to `tick` takes 2–3 `clk` cycles.
- Step load: `note`, `step`, `gate`, and `step_strobe` update on the `clk` edge after the loading `tick`. All four change in the same cycle.
- Gate fall: the `clk` edge after the tick on which `cnt` reaches `gate_len`.
- Stop: `gate` falls 1 `clk` after `run` is sampled low.
- Write-to-visibility: a RAM write in cycle N is visible to any step load at cycle N+1 or later.

## Configuration
- `STEP_SEQUENCER_SWING_EN` defined: `swing` is clamped to ⌊P/2⌋−1. Even-index steps use P = period + swing; odd-index steps use P = period − swing. The pair total is unchanged. `gate_len` is clamped against each step's own P.
- Not defined: the `swing` port is present but ignored, and every step uses P = effective `step_period`.

## Test plan
- Reset/idle: hold `rst`=0, toggle `sample_clock`, release with `run`=0 → `gate`=0, `note`=0, `step`=0, no `step_strobe` for 100 ticks.
- Basic play: write steps 0..3 = notes 60/64/67/72 with all gates set; `step_period`=8, `gate_len`=4, `loop_last`=3, `run`=1 → `step` sequence 0,1,2,3,0; each `note` matches its step; `gate` high for 4 ticks then low for 4; `step_strobe` period = 8 ticks.
- Rests and clamp: step 1 gate bit = 0, `gate_len`=20, `step_period`=8 → step 1 `gate` stays low; other steps have `gate` high for 7 ticks, low for 1.
- Degenerate period: `step_period`=0 → step advances every 2 ticks; with `gate_len`=5, `gate` is high 1 tick and low 1 tick.
- Stop/restart and live write: stop at step 2 → `gate`=0 within 1 `clk` and `step`=0. While running, write step 2 note=50 during step 2 → current `note` unchanged; the next visit plays 50.
- Swing (macro defined): `step_period`=10, `swing`=3 → even steps last 13 ticks, odd steps 7. With `swing`=9 the clamp applies: even steps last 14 ticks, odd steps 6. Without the macro, every step lasts 10 ticks.
